// File: rtl/mem_line_engine.sv
// Miss-service initiator: optional victim writeback followed by a block refill over a block-wide memory port.
// Accepts one request at a time and signals completion with a single-cycle done pulse.
module mem_line_engine #(
   parameter int RD_LATENCY = 1,
   parameter int CNT_WIDTH  = 16,
   parameter int PA_WIDTH   = 20,
   parameter int BLK_WIDTH  = 128,
   parameter int BYTE       = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 req_valid,
   output logic                 req_ready,
   input  logic                 req_fill,
   input  logic                 req_wb,
   input  logic [PA_WIDTH-1:0]  req_fill_addr,
   input  logic [PA_WIDTH-1:0]  req_wb_addr,
   input  logic [BLK_WIDTH-1:0] req_wb_data,
   output logic                 done,
   output logic [BLK_WIDTH-1:0] resp_data,
   output logic [PA_WIDTH-1:0]  mem_addr,
   output logic                 mem_rd_en,
   output logic                 mem_wr_en,
   output logic [BLK_WIDTH-1:0] mem_wr_data,
   input  logic [BLK_WIDTH-1:0] mem_rd_data,
   output logic [CNT_WIDTH-1:0] fill_count,
   output logic [CNT_WIDTH-1:0] wb_count
);

   localparam int OFF = $clog2(BLK_WIDTH / BYTE);
   localparam int WCW = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;
   localparam logic [PA_WIDTH-1:0] ALIGN_MASK = ~PA_WIDTH'((64'd1 << OFF) - 64'd1);

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_WB   = 3'd1;
   localparam logic [2:0] S_RD   = 3'd2;
   localparam logic [2:0] S_WAIT = 3'd3;
   localparam logic [2:0] S_DONE = 3'd4;

   logic [2:0]           state_q, state_d;
   logic [PA_WIDTH-1:0]  fill_addr_q, fill_addr_d;
   logic                 fill_q, fill_d;
   logic [WCW-1:0]       wait_q, wait_d;
   logic [PA_WIDTH-1:0]  mem_addr_q, mem_addr_d;
   logic [BLK_WIDTH-1:0] wr_data_q, wr_data_d;
   logic [BLK_WIDTH-1:0] resp_q, resp_d;
   logic [CNT_WIDTH-1:0] fill_cnt_q, fill_cnt_d;
   logic [CNT_WIDTH-1:0] wb_cnt_q, wb_cnt_d;

   // The address and write-data registers double as the request latches: they are
   // loaded on the transition into the state that first drives them.
   always_comb begin
      state_d     = state_q;
      fill_addr_d = fill_addr_q;
      fill_d      = fill_q;
      wait_d      = wait_q;
      mem_addr_d  = mem_addr_q;
      wr_data_d   = wr_data_q;
      resp_d      = resp_q;
      fill_cnt_d  = fill_cnt_q;
      wb_cnt_d    = wb_cnt_q;
      case (state_q)
         S_IDLE: begin
            if (req_valid) begin
               fill_addr_d = req_fill_addr & ALIGN_MASK;
               fill_d      = req_fill;
               if (req_wb) begin
                  state_d    = S_WB;
                  mem_addr_d = req_wb_addr & ALIGN_MASK;
                  wr_data_d  = req_wb_data;
               end else if (req_fill) begin
                  state_d    = S_RD;
                  mem_addr_d = req_fill_addr & ALIGN_MASK;
               end else begin
                  state_d    = S_DONE;
               end
            end
         end
         S_WB: begin
            wb_cnt_d = wb_cnt_q + 1'b1;
            if (fill_q) begin
               state_d    = S_RD;
               mem_addr_d = fill_addr_q;
            end else begin
               state_d    = S_DONE;
            end
         end
         S_RD: begin
            state_d = S_WAIT;
            wait_d  = WCW'(RD_LATENCY - 1);
         end
         S_WAIT: begin
            if (wait_q == '0) begin
               resp_d  = mem_rd_data;
               state_d = S_DONE;
            end else begin
               wait_d  = wait_q - 1'b1;
            end
         end
         S_DONE: begin
            if (fill_q) begin
               fill_cnt_d = fill_cnt_q + 1'b1;
            end
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         fill_addr_q <= '0;
         fill_q      <= 1'b0;
         wait_q      <= '0;
         mem_addr_q  <= '0;
         wr_data_q   <= '0;
         resp_q      <= '0;
         fill_cnt_q  <= '0;
         wb_cnt_q    <= '0;
      end else begin
         state_q     <= state_d;
         fill_addr_q <= fill_addr_d;
         fill_q      <= fill_d;
         wait_q      <= wait_d;
         mem_addr_q  <= mem_addr_d;
         wr_data_q   <= wr_data_d;
         resp_q      <= resp_d;
         fill_cnt_q  <= fill_cnt_d;
         wb_cnt_q    <= wb_cnt_d;
      end
   end

   assign req_ready   = (state_q == S_IDLE);
   assign done        = (state_q == S_DONE);
   assign mem_wr_en   = (state_q == S_WB);
   assign mem_rd_en   = (state_q == S_RD);
   assign mem_addr    = mem_addr_q;
   assign mem_wr_data = wr_data_q;
   assign resp_data   = resp_q;
   assign fill_count  = fill_cnt_q;
   assign wb_count    = wb_cnt_q;

endmodule
